ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- EX-stage multiply/divide engine with the architectural HI/LO register pair.
- Sits directly downstream of the ID/EX pipeline register and consumes its decoded HI/LO control and its `regfile_out1_out`/`regfile_out2_out` operands.
- Runs MULT/MULTU/DIV/DIVU iteratively and accepts MTHI/MTLO writes.
- Drives `hi`/`lo` back to the ID-stage read path. Asserts `busy` so the hazard logic can freeze the front of the pipe.

Parameters:
- DATA_BITS, 32, operand and HI/LO width.
- CNT_BITS, 6, iteration counter width; must hold the value DATA_BITS.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- zero  in  1  synchronous flush: aborts any operation in progress
- start_mul  in  1  begin multiply; sampled only in IDLE
- start_div  in  1  begin divide; sampled only in IDLE
- op_signed  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU)
- op_a  in  DATA_BITS  rs operand (multiplicand / dividend)
- op_b  in  DATA_BITS  rt operand (multiplier / divisor)
- wr_hi  in  1  MTHI write strobe
- wr_lo  in  1  MTLO write strobe
- wr_data  in  DATA_BITS  MTHI/MTLO data
- hi  out  DATA_BITS  HI register
- lo  out  DATA_BITS  LO register
- busy  out  1  operation in progress (state != IDLE)
- done  out  1  one-cycle pulse in the cycle HI/LO take a result

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - hi = 0, lo = 0, busy = 0, done = 0.
  - State = IDLE; counter and internal accumulators cleared.
- States:
  - IDLE:
    - start_mul -> MUL.
    - start_div -> DIV.
    - If both starts are high, start_mul wins.
    - On start, latch operands. In signed mode latch magnitudes and record sign_a and sign_b. Counter = 0.
  - MUL: radix-2 shift-add.
    - One iteration per cycle over a 2*DATA_BITS product; DATA_BITS iterations.
    - After the last iteration -> FIX.
  - DIV: restoring division on magnitudes; one quotient bit per cycle; DATA_BITS iterations; -> FIX.
  - FIX: one cycle.
    - Apply the sign correction and write HI/LO.
    - done = 1 in this cycle; -> IDLE.
- Latency:
  - Start sampled at edge 0.
  - hi/lo are updated at edge DATA_BITS+1 (33 for the default).
  - busy is high for cycles 1..DATA_BITS+1 and low again after the FIX edge.
- Multiply result:
  - {hi, lo} = full 64-bit product.
  - Signed: negate the 64-bit product iff sign_a XOR sign_b.
- Divide result:
  - lo = quotient, hi = remainder.
  - Signed: quotient negated iff signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) -> lo = 0x80000000, hi = 0. No trap.
  - Divisor = 0 -> lo = 0xFFFFFFFF, hi = op_a as latched, unmodified. Same result in signed and unsigned mode. No trap.
- MTHI/MTLO:
  - In IDLE, wr_hi/wr_lo load wr_data at the next edge.
  - Both strobes together load both registers.
  - While busy, wr_hi/wr_lo are ignored.
- Ignored starts: start_mul/start_div while busy are ignored; hi/lo are untouched until FIX.
- zero (flush):
  - Forces IDLE at the next edge; the partial result is discarded; hi/lo keep their prior values; done stays 0.
  - zero has priority over start, wr_hi/wr_lo and FIX: a flush during FIX suppresses the write.
- Reset mid-operation: immediate return to reset values; no result is written.
- Outputs:
  - hi/lo are direct register outputs with no bypass. A read in the same cycle as an MTHI sees the old value; forwarding is the hazard unit's job.
  - busy is a pure state decode with no combinational path from the inputs.

Decomposition:
- Shared pipeline package holds:
  - State encoding constants: IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3.
  - DATA_BITS default.
  - Divide-by-zero quotient constant (all ones).
- One natural sub-module: muldiv_iter_core.
  - Contains the shared 2*DATA_BITS shift register, the adder/subtractor and the counter.
  - Selects add (MUL) or trial-subtract (DIV) per iteration.
- The top level keeps the FSM, sign handling, the HI/LO registers and the MTHI/MTLO path.

Test Plan:
- Signed multiply: MULT op_a = 0xFFFFFFFE (-2), op_b = 3 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; done at cycle 33; busy high for cycles 1..33.
- Unsigned multiply: MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- Signed divide with overflow case:
  - DIV -7 / 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
  - DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- Divide by zero: DIVU 0x1234 / 0 -> lo = 0xFFFFFFFF, hi = 0x00001234.
- Flush mid-operation:
  - Preload hi = 0xAA, lo = 0xBB via MTHI/MTLO; start MULT 5*5; assert zero at cycle 10.
  - Required: busy = 0 at cycle 11; hi/lo remain 0xAA/0xBB; no done pulse.
- Ignored inputs while busy and async reset:
  - wr_hi and start_div during a running DIV are ignored; the original result lands at cycle 33.
  - rst_n pulsed low mid-op -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package ex_muldiv_unit_pkg;

   localparam int unsigned DATA_BITS_DEF = 32;

   // Quotient fill bit for divide-by-zero: the quotient is all ones at any width.
   localparam logic DIV0_Q_FILL = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_e;

endpackage

// File: rtl/ex_muldiv_unit_iter_core.sv
// Iterative datapath: shared 2*DATA_BITS shift register, one adder/subtractor and
// the iteration counter. Does shift-add multiply or restoring divide on magnitudes.
module muldiv_iter_core
   import ex_muldiv_unit_pkg::*;
#(
   parameter int unsigned DATA_BITS = DATA_BITS_DEF,
   parameter int unsigned CNT_BITS  = 6
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   load_i,
   input  logic                   div_i,
   input  logic                   step_i,
   input  logic [DATA_BITS-1:0]   a_i,
   input  logic [DATA_BITS-1:0]   b_i,
   output logic                   last_o,
   output logic [2*DATA_BITS-1:0] acc_o
);

   logic [2*DATA_BITS-1:0] acc_q, acc_d;
   logic [DATA_BITS-1:0]   opb_q;
   logic                   div_q;
   logic [CNT_BITS-1:0]    cnt_q;
   logic [DATA_BITS+1:0]   alu_x, alu_y, alu_r;
   logic                   alu_cin;

   always_comb begin
      alu_x   = '0;
      alu_y   = '0;
      alu_cin = 1'b0;
      acc_d   = acc_q;
      // Divide: trial-subtract the divisor from {rem, next dividend bit}; the
      // top bit of the (DATA_BITS+2)-wide result is the borrow.
      if (div_q) begin
         alu_x   = {1'b0, acc_q[2*DATA_BITS-1:DATA_BITS-1]};
         alu_y   = ~{2'b00, opb_q};
         alu_cin = 1'b1;
      end else begin
         alu_x = {2'b00, acc_q[2*DATA_BITS-1:DATA_BITS]};
         alu_y = {2'b00, opb_q};
      end
      alu_r = alu_x + alu_y + {{(DATA_BITS+1){1'b0}}, alu_cin};
      if (div_q) begin
         if (!alu_r[DATA_BITS+1])
            acc_d = {alu_r[DATA_BITS-1:0], acc_q[DATA_BITS-2:0], 1'b1};
         else
            acc_d = {acc_q[2*DATA_BITS-2:0], 1'b0};
      end else if (acc_q[0]) begin
         acc_d = {alu_r[DATA_BITS:0], acc_q[DATA_BITS-1:1]};
      end else begin
         acc_d = {1'b0, acc_q[2*DATA_BITS-1:1]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
         opb_q <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else if (load_i) begin
         acc_q <= {{DATA_BITS{1'b0}}, a_i};
         opb_q <= b_i;
         div_q <= div_i;
         cnt_q <= '0;
      end else if (step_i) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + CNT_BITS'(1);
      end
   end

   assign last_o = step_i && (cnt_q == CNT_BITS'(DATA_BITS - 1));
   assign acc_o  = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: control FSM, sign handling, HI/LO registers and
// the MTHI/MTLO write path around the shared iterative core.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int unsigned DATA_BITS = DATA_BITS_DEF,
   parameter int unsigned CNT_BITS  = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 zero,
   input  logic                 start_mul,
   input  logic                 start_div,
   input  logic                 op_signed,
   input  logic [DATA_BITS-1:0] op_a,
   input  logic [DATA_BITS-1:0] op_b,
   input  logic                 wr_hi,
   input  logic                 wr_lo,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic [DATA_BITS-1:0] hi,
   output logic [DATA_BITS-1:0] lo,
   output logic                 busy,
   output logic                 done
);

   state_e                 state_q;
   logic [DATA_BITS-1:0]   hi_q, lo_q, a_raw_q;
   logic                   done_q, div_q, sign_a_q, sign_b_q, b_zero_q;
   logic [DATA_BITS-1:0]   a_mag, b_mag, quo, rem, hi_d, lo_d;
   logic [2*DATA_BITS-1:0] core_acc, prod;
   logic                   core_load, core_step, core_last;

   always_comb begin
      a_mag     = (op_signed && op_a[DATA_BITS-1]) ? -op_a : op_a;
      b_mag     = (op_signed && op_b[DATA_BITS-1]) ? -op_b : op_b;
      core_load = (state_q == IDLE) && !zero && (start_mul || start_div);
      core_step = ((state_q == MUL) || (state_q == DIV)) && !zero;
   end

   muldiv_iter_core #(
      .DATA_BITS(DATA_BITS),
      .CNT_BITS (CNT_BITS)
   ) u_core (
      .clk_i (clk),
      .rst_ni(rst_n),
      .load_i(core_load),
      .div_i (!start_mul),
      .step_i(core_step),
      .a_i   (a_mag),
      .b_i   (b_mag),
      .last_o(core_last),
      .acc_o (core_acc)
   );

   always_comb begin
      prod = (sign_a_q ^ sign_b_q) ? -core_acc : core_acc;
      quo  = core_acc[DATA_BITS-1:0];
      rem  = core_acc[2*DATA_BITS-1:DATA_BITS];
      hi_d = prod[2*DATA_BITS-1:DATA_BITS];
      lo_d = prod[DATA_BITS-1:0];
      // Divide-by-zero returns the raw dividend, bypassing the sign fix-up.
      if (div_q) begin
         if (b_zero_q) begin
            hi_d = a_raw_q;
            lo_d = {DATA_BITS{DIV0_Q_FILL}};
         end else begin
            hi_d = sign_a_q ? -rem : rem;
            lo_d = (sign_a_q ^ sign_b_q) ? -quo : quo;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         div_q    <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         b_zero_q <= 1'b0;
         a_raw_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (zero) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_mul || start_div) begin
                     state_q  <= start_mul ? MUL : DIV;
                     div_q    <= !start_mul;
                     sign_a_q <= op_signed && op_a[DATA_BITS-1];
                     sign_b_q <= op_signed && op_b[DATA_BITS-1];
                     b_zero_q <= (op_b == '0);
                     a_raw_q  <= op_a;
                  end
                  if (wr_hi) hi_q <= wr_data;
                  if (wr_lo) lo_q <= wr_data;
               end
               MUL, DIV: begin
                  if (core_last) state_q <= FIX;
               end
               FIX: begin
                  hi_q    <= hi_d;
                  lo_q    <= lo_d;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign done = done_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: cycle-level reference model plus
// directed scenarios and a randomized traffic phase.
module tb_ex_muldiv_unit;

   localparam int unsigned N = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         zero = 1'b0, start_mul = 1'b0, start_div = 1'b0, op_signed = 1'b0;
   logic [N-1:0] op_a = '0, op_b = '0, wr_data = '0;
   logic         wr_hi = 1'b0, wr_lo = 1'b0;
   logic [N-1:0] hi, lo;
   logic         busy, done;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   ex_muldiv_unit #(.DATA_BITS(N), .CNT_BITS(6)) dut (
      .clk(clk), .rst_n(rst_n), .zero(zero), .start_mul(start_mul), .start_div(start_div),
      .op_signed(op_signed), .op_a(op_a), .op_b(op_b), .wr_hi(wr_hi), .wr_lo(wr_lo),
      .wr_data(wr_data), .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // {hi, lo} an operation must produce, from plain arithmetic.
   function automatic logic [63:0] ref_result(input bit is_div, input bit sgn,
                                             input logic [N-1:0] a, input logic [N-1:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!is_div) begin
         if (sgn) p = 64'(sa * sb);
         else     p = {32'h0, a} * {32'h0, b};
         return p;
      end
      if (b == '0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         q = sa / sb;
         r = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   // Reference model: an accepted op is fully computed up front and its
   // result is published N+1 cycles later unless flushed.
   logic [N-1:0] exp_hi = '0, exp_lo = '0;
   logic         exp_busy = 1'b0, exp_done = 1'b0;
   logic [63:0]  pend_res = '0;
   int unsigned  remaining = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_hi = '0; exp_lo = '0; exp_busy = 1'b0; exp_done = 1'b0; remaining = 0;
      end else begin
         exp_done = 1'b0;
         if (zero) begin
            remaining = 0;
         end else if (remaining != 0) begin
            if (remaining == 1) begin
               {exp_hi, exp_lo} = pend_res;
               exp_done = 1'b1;
            end
            remaining--;
         end else begin
            if (start_mul || start_div) begin
               pend_res  = ref_result(!start_mul, op_signed, op_a, op_b);
               remaining = N + 1;
            end
            if (wr_hi) exp_hi = wr_data;
            if (wr_lo) exp_lo = wr_data;
         end
         exp_busy = (remaining != 0);
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic run_op(input bit is_div, input bit sgn, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N-1:0] eh,
                         input logic [N-1:0] el, input bit disturb, input string nm);
      int unsigned k;
      bit seen;
      @(negedge clk);
      start_mul = !is_div; start_div = is_div; op_signed = sgn; op_a = a; op_b = b;
      @(posedge clk); #1;
      start_mul = 1'b0; start_div = 1'b0; op_a = $urandom; op_b = $urandom;
      check({nm, "_busy0"}, 64'(busy), 64'd1);
      k = 0; seen = 1'b0;
      while (!seen && k < 40) begin
         @(posedge clk); #1;
         k++;
         seen = done;
         if (!seen) check({nm, "_busy"}, 64'(busy), 64'd1);
         if (disturb && k == 5) begin
            wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
            start_div = 1'b1; start_mul = 1'b1; op_a = 32'h55; op_b = 32'h3;
         end
         if (disturb && k == 6) begin
            wr_hi = 1'b0; wr_lo = 1'b0; start_div = 1'b0; start_mul = 1'b0;
         end
      end
      check({nm, "_latency"}, 64'(k), 64'(N + 1));
      check({nm, "_busy_end"}, 64'(busy), 64'd0);
      check({nm, "_hi"}, 64'(hi), 64'(eh));
      check({nm, "_lo"}, 64'(lo), 64'(el));
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            vectors++;
            if (hi !== exp_hi || lo !== exp_lo || busy !== exp_busy || done !== exp_done) begin
               miscompares++;
               $display("FAIL cycle: got hi=%h lo=%h busy=%b done=%b expected hi=%h lo=%h busy=%b done=%b at %0t",
                        hi, lo, busy, done, exp_hi, exp_lo, exp_busy, exp_done, $time);
            end
         end
      join_none

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_lo", 64'(lo), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      rst_n = 1'b1;

      run_op(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult_neg");
      run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
      run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
      run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_ovf");
      run_op(1'b1, 1'b0, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, "divu_zero");
      run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, "div_zero_s");

      // Flush mid-op: preload HI/LO, start 5*5, assert zero for edge 10.
      @(negedge clk); wr_hi = 1'b1; wr_data = 32'hAA;
      @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'hBB;
      @(negedge clk); wr_lo = 1'b0;
      check("mthi", 64'(hi), 64'hAA);
      check("mtlo", 64'(lo), 64'hBB);
      start_mul = 1'b1; op_signed = 1'b1; op_a = 32'd5; op_b = 32'd5;
      @(negedge clk); start_mul = 1'b0;
      repeat (9) @(negedge clk);
      zero = 1'b1;
      @(negedge clk); zero = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_hi", 64'(hi), 64'hAA);
      check("flush_lo", 64'(lo), 64'hBB);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("flush_no_done", 64'(done), 64'd0);
      end

      run_op(1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, "divu_disturb");

      // Async reset in the middle of a multiply.
      @(negedge clk); start_mul = 1'b1; op_signed = 1'b0; op_a = 32'd7; op_b = 32'd9;
      @(negedge clk); start_mul = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("areset_hi", 64'(hi), 64'd0);
      check("areset_lo", 64'(lo), 64'd0);
      check("areset_busy", 64'(busy), 64'd0);
      check("areset_done", 64'(done), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // Random traffic; the per-cycle comparison checks every cycle.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         start_mul = ($urandom_range(0, 99) < 8);
         start_div = ($urandom_range(0, 99) < 8);
         op_signed = $urandom_range(0, 1);
         wr_hi     = ($urandom_range(0, 99) < 10);
         wr_lo     = ($urandom_range(0, 99) < 10);
         wr_data   = $urandom;
         zero      = ($urandom_range(0, 199) == 0);
         case ($urandom_range(0, 5))
            0: op_a = 32'h8000_0000;
            1: op_a = 32'hFFFF_FFFF;
            2: op_a = 32'($urandom_range(0, 300));
            default: op_a = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0: op_b = 32'h0;
            1: op_b = 32'hFFFF_FFFF;
            2: op_b = 32'($urandom_range(1, 20));
            default: op_b = $urandom;
         endcase
      end
      @(negedge clk);
      start_mul = 1'b0; start_div = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; zero = 1'b0;
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
